base_demux_reg: RTL and testbench

//  Registered 1-to-2 demultiplexer: inverse of the 32-bit 2:1 base mux. Steers one

---
 rtl/base_mux_pkg.sv | 15 +
 rtl/base_demux_reg_if.sv | 31 +++
 rtl/base_demux_slot.sv | 39 +++
 rtl/base_demux_reg.sv | 77 +++++++
 tb/tb_base_demux_reg.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/base_mux_pkg.sv
// Shared constants for the 2:1 base mux and its registered 1-to-2 demux counterpart.
// The select encoding must stay identical between the mux and the demux.
package base_mux_pkg;

  localparam int DATA_W = 32;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/base_demux_reg_if.sv
// Stream bundle of base_demux_reg: one input stream, two output streams, beat counters.
// slave = the demux itself, master = whatever drives the input and sinks the outputs.
interface base_demux_reg_if #(
  parameter int WIDTH = base_mux_pkg::DATA_W,
  parameter int CNT_W = 16
);

  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
  logic [CNT_W-1:0] a_count;
  logic [CNT_W-1:0] b_count;

  modport slave (
    input  in_data, in_sel, in_valid, a_ready, b_ready,
    output in_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
  );

  modport master (
    output in_data, in_sel, in_valid, a_ready, b_ready,
    input  in_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
  );

endinterface

// File: rtl/base_demux_slot.sv
// One-entry valid/ready holding register: loads a beat, holds it until the sink takes it.
// A load on the same edge as a drain replaces the held beat, giving 1 beat/cycle.
module base_demux_slot
  import base_mux_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_drain,
  output logic             o_can_load
);

  slot_state_e      r_state;
  logic [WIDTH-1:0] r_data;

  assign o_valid    = (r_state == SLOT_FULL);
  assign o_data     = r_data;
  assign o_drain    = o_valid & i_ready;
  assign o_can_load = ~o_valid | i_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= SLOT_EMPTY;
      r_data  <= '0;
    end else if (i_load) begin
      r_state <= SLOT_FULL;
      r_data  <= i_data;
    end else if (o_drain) begin
      r_state <= SLOT_EMPTY;
    end
  end

endmodule

// File: rtl/base_demux_reg.sv
// Registered 1-to-2 demux: steers each input beat to slot A (sel=0) or B (sel=1).
// Optional feature macro BASE_DEMUX_CNT_EN adds per-output delivered-beat counters.
module base_demux_reg
  import base_mux_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  base_demux_reg_if.slave  bus
);

  // Index 0 is slot A, index 1 is slot B, matching the select encoding.
  logic             w_load     [2];
  logic             w_ready    [2];
  logic             w_valid    [2];
  logic [WIDTH-1:0] w_data     [2];
  logic             w_drain    [2];
  logic             w_can_load [2];
  logic             w_accept;

  assign w_ready[0] = bus.a_ready;
  assign w_ready[1] = bus.b_ready;

  // in_ready only looks at the addressed slot, so a stalled sink never blocks the other.
  assign bus.in_ready = rst_n & ((bus.in_sel == SEL_A) ? w_can_load[0] : w_can_load[1]);
  assign w_accept     = bus.in_valid & bus.in_ready;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      assign w_load[gi] = w_accept & (bus.in_sel == ((gi == 0) ? SEL_A : SEL_B));

      base_demux_slot #(.WIDTH(WIDTH)) u_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load[gi]),
        .i_data     (bus.in_data),
        .i_ready    (w_ready[gi]),
        .o_valid    (w_valid[gi]),
        .o_data     (w_data[gi]),
        .o_drain    (w_drain[gi]),
        .o_can_load (w_can_load[gi])
      );
    end
  endgenerate

  assign bus.a_valid = w_valid[0];
  assign bus.a_data  = w_data[0];
  assign bus.b_valid = w_valid[1];
  assign bus.b_data  = w_data[1];

`ifdef BASE_DEMUX_CNT_EN
  logic [CNT_W-1:0] r_count [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_count[gi] <= '0;
        end else if (w_drain[gi]) begin
          r_count[gi] <= r_count[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign bus.a_count = r_count[0];
  assign bus.b_count = r_count[1];
`else
  logic w_unused_drain;
  assign w_unused_drain = w_drain[0] & w_drain[1];
  assign bus.a_count    = '0;
  assign bus.b_count    = '0;
`endif

endmodule

// File: tb/tb_base_demux_reg.sv
// Self-checking bench for base_demux_reg: directed scenarios plus random traffic
// checked against a queue-based model of the two output slots.
module tb_base_demux_reg;
  import base_mux_pkg::*;

  localparam int WIDTH = DATA_W;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  base_demux_reg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  base_demux_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model: each output is a queue of beats waiting at that sink (at most one).
  logic [WIDTH-1:0] q_a[$];
  logic [WIDTH-1:0] q_b[$];
  int exp_a_cnt = 0;
  int exp_b_cnt = 0;

  function automatic logic model_in_ready();
    if (!rst_n) return 1'b0;
    if (bus.in_sel == SEL_A) return (q_a.size() == 0) || bus.a_ready;
    return (q_b.size() == 0) || bus.b_ready;
  endfunction

  function automatic int cnt_exp(int c);
`ifdef BASE_DEMUX_CNT_EN
    return c;
`else
    return 0;
`endif
  endfunction

  task automatic set_in(logic v, logic s, logic [WIDTH-1:0] d, logic ar, logic br);
    bus.in_valid = v;
    bus.in_sel   = s;
    bus.in_data  = d;
    bus.a_ready  = ar;
    bus.b_ready  = br;
    #1;
  endtask

  // Advance one clock edge, applying the transfer rules to the model first.
  task automatic step();
    logic acc;
    acc = bus.in_valid && model_in_ready();
    if (!rst_n) begin
      q_a.delete();
      q_b.delete();
      exp_a_cnt = 0;
      exp_b_cnt = 0;
    end else begin
      if (q_a.size() > 0 && bus.a_ready) begin
        void'(q_a.pop_front());
        exp_a_cnt = (exp_a_cnt + 1) % (1 << CNT_W);
      end
      if (q_b.size() > 0 && bus.b_ready) begin
        void'(q_b.pop_front());
        exp_b_cnt = (exp_b_cnt + 1) % (1 << CNT_W);
      end
      if (acc) begin
        if (bus.in_sel == SEL_A) q_a.push_back(bus.in_data);
        else q_b.push_back(bus.in_data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(1'b1, SEL_B, 32'hDEAD_BEEF, 1'b1, 1'b1);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready);
    end
    step();
    step();
    checks++;
    if (bus.a_valid !== 1'b0 || bus.b_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got a=%b b=%b exp a=0 b=0", bus.a_valid, bus.b_valid);
    end
    checks++;
    if (bus.a_data !== '0 || bus.b_data !== '0) begin
      errors++; $display("FAIL reset_data got a=%h b=%h exp 0", bus.a_data, bus.b_data);
    end
    checks++;
    if (bus.a_count !== '0 || bus.b_count !== '0) begin
      errors++; $display("FAIL reset_count got a=%0d b=%0d exp 0", bus.a_count, bus.b_count);
    end
    rst_n = 1'b1;
    set_in(1'b0, SEL_A, '0, 1'b1, 1'b1);
    $display("test_reset done errors=%0d", errors);
  endtask

  task automatic test_route();
    set_in(1'b1, SEL_B, 32'd1, 1'b1, 1'b1);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL route_in_ready got=%b exp=1", bus.in_ready);
    end
    step();
    checks++;
    if (bus.b_valid !== 1'b1 || bus.b_data !== 32'd1 || bus.a_valid !== 1'b0) begin
      errors++; $display("FAIL route_b got b_valid=%b b_data=%h a_valid=%b exp 1 00000001 0",
                         bus.b_valid, bus.b_data, bus.a_valid);
    end
    set_in(1'b1, SEL_A, 32'd0, 1'b1, 1'b1);
    step();
    checks++;
    if (bus.a_valid !== 1'b1 || bus.a_data !== 32'd0 || bus.b_valid !== 1'b0) begin
      errors++; $display("FAIL route_a got a_valid=%b a_data=%h b_valid=%b exp 1 00000000 0",
                         bus.a_valid, bus.a_data, bus.b_valid);
    end
    set_in(1'b0, SEL_A, '0, 1'b1, 1'b1);
    step();
    $display("test_route done errors=%0d", errors);
  endtask

  task automatic test_backpressure();
    set_in(1'b1, SEL_B, 32'hAAAA_0001, 1'b1, 1'b0);
    step();
    set_in(1'b1, SEL_B, 32'hAAAA_0002, 1'b1, 1'b0);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_blocked got in_ready=%b exp=0", bus.in_ready);
    end
    step();
    checks++;
    if (bus.b_valid !== 1'b1 || bus.b_data !== 32'hAAAA_0001) begin
      errors++; $display("FAIL bp_hold got b_valid=%b b_data=%h exp 1 aaaa0001", bus.b_valid, bus.b_data);
    end
    set_in(1'b1, SEL_A, 32'h5555_0003, 1'b1, 1'b0);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_other got in_ready=%b exp=1", bus.in_ready);
    end
    step();
    checks++;
    if (bus.a_valid !== 1'b1 || bus.a_data !== 32'h5555_0003 || bus.b_data !== 32'hAAAA_0001) begin
      errors++; $display("FAIL bp_a got a_valid=%b a_data=%h b_data=%h exp 1 55550003 aaaa0001",
                         bus.a_valid, bus.a_data, bus.b_data);
    end
    set_in(1'b1, SEL_B, 32'hAAAA_0002, 1'b1, 1'b1);
    step();
    checks++;
    if (bus.b_valid !== 1'b1 || bus.b_data !== 32'hAAAA_0002) begin
      errors++; $display("FAIL bp_follow got b_valid=%b b_data=%h exp 1 aaaa0002", bus.b_valid, bus.b_data);
    end
    set_in(1'b0, SEL_A, '0, 1'b1, 1'b1);
    step();
    $display("test_backpressure done errors=%0d", errors);
  endtask

  task automatic test_simultaneous();
    set_in(1'b1, SEL_A, 32'h1234_0001, 1'b0, 1'b1);
    step();
    set_in(1'b1, SEL_A, 32'h1234_0002, 1'b1, 1'b1);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.a_data !== 32'h1234_0001) begin
      errors++; $display("FAIL simul_pre got in_ready=%b a_data=%h exp 1 12340001", bus.in_ready, bus.a_data);
    end
    step();
    checks++;
    if (bus.a_valid !== 1'b1 || bus.a_data !== 32'h1234_0002 || q_a.size() != 1) begin
      errors++; $display("FAIL simul_post got a_valid=%b a_data=%h exp 1 12340002", bus.a_valid, bus.a_data);
    end
    set_in(1'b0, SEL_A, '0, 1'b1, 1'b1);
    step();
    $display("test_simultaneous done errors=%0d", errors);
  endtask

  task automatic test_reset_mid();
    set_in(1'b1, SEL_A, 32'hC0DE_000A, 1'b0, 1'b0);
    step();
    set_in(1'b1, SEL_B, 32'hC0DE_000B, 1'b0, 1'b0);
    step();
    checks++;
    if (bus.a_valid !== 1'b1 || bus.b_valid !== 1'b1) begin
      errors++; $display("FAIL mid_full got a=%b b=%b exp 1 1", bus.a_valid, bus.b_valid);
    end
    rst_n = 1'b0;
    set_in(1'b0, SEL_A, '0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    checks++;
    if (bus.a_valid !== 1'b0 || bus.b_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset got a=%b b=%b exp 0 0", bus.a_valid, bus.b_valid);
    end
    set_in(1'b1, SEL_B, 32'hC0DE_000C, 1'b1, 1'b1);
    step();
    checks++;
    if (bus.b_valid !== 1'b1 || bus.b_data !== 32'hC0DE_000C || bus.a_valid !== 1'b0) begin
      errors++; $display("FAIL mid_after got b_valid=%b b_data=%h a_valid=%b exp 1 c0de000c 0",
                         bus.b_valid, bus.b_data, bus.a_valid);
    end
    set_in(1'b0, SEL_A, '0, 1'b1, 1'b1);
    step();
    $display("test_reset_mid done errors=%0d", errors);
  endtask

  task automatic test_count();
    rst_n = 1'b0;
    set_in(1'b0, SEL_A, '0, 1'b1, 1'b1);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      set_in(1'b1, SEL_A, $urandom, 1'b1, 1'b1);
      step();
    end
    set_in(1'b0, SEL_A, '0, 1'b1, 1'b1);
    step();
    checks++;
    if (int'(bus.a_count) != cnt_exp(1) || int'(bus.b_count) != 0) begin
      errors++; $display("FAIL count_wrap got a=%0d b=%0d exp a=%0d b=0", bus.a_count, bus.b_count, cnt_exp(1));
    end
    $display("test_count done errors=%0d", errors);
  endtask

  task automatic test_random();
    logic v, s, ar, br;
    for (int i = 0; i < 400; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      s  = $urandom_range(0, 1);
      ar = ($urandom_range(0, 9) < 6);
      br = ($urandom_range(0, 9) < 6);
      set_in(v, s, $urandom, ar, br);
      checks++;
      if (bus.in_ready !== model_in_ready()) begin
        errors++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", i, bus.in_ready, model_in_ready());
      end
      step();
      checks++;
      if (bus.a_valid !== (q_a.size() != 0) || (q_a.size() != 0 && bus.a_data !== q_a[0])) begin
        errors++; $display("FAIL rand_a cyc=%0d got v=%b d=%h exp v=%b d=%h", i, bus.a_valid, bus.a_data,
                           q_a.size() != 0, (q_a.size() != 0) ? q_a[0] : '0);
      end
      checks++;
      if (bus.b_valid !== (q_b.size() != 0) || (q_b.size() != 0 && bus.b_data !== q_b[0])) begin
        errors++; $display("FAIL rand_b cyc=%0d got v=%b d=%h exp v=%b d=%h", i, bus.b_valid, bus.b_data,
                           q_b.size() != 0, (q_b.size() != 0) ? q_b[0] : '0);
      end
      checks++;
      if (int'(bus.a_count) != cnt_exp(exp_a_cnt) || int'(bus.b_count) != cnt_exp(exp_b_cnt)) begin
        errors++; $display("FAIL rand_count cyc=%0d got a=%0d b=%0d exp a=%0d b=%0d", i, bus.a_count,
                           bus.b_count, cnt_exp(exp_a_cnt), cnt_exp(exp_b_cnt));
      end
    end
    $display("test_random done errors=%0d", errors);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sel   = SEL_A;
    bus.in_data  = '0;
    bus.a_ready  = 1'b0;
    bus.b_ready  = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_route();
    test_backpressure();
    test_simultaneous();
    test_reset_mid();
    test_count();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
